// File: rtl/core_shift_reg_multi.sv
// Multi-lane shift register with a runtime-selectable output depth and fill/valid tracking.
// Optional macro SHIFT_REG_TAPS_EN drives taps_o from the stage array; otherwise taps_o is zero.
module core_shift_reg_multi #(
  parameter int unsigned Bits     = 8,
  parameter int unsigned Channels = 1,
  parameter int unsigned Length   = 4,
  parameter int unsigned DepthW   = $clog2(Length + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  logic [Bits-1:0]                    rst_val_i,
  input  logic [DepthW-1:0]                  depth_i,
  input  logic [Channels*Bits-1:0]           data_i,
  output logic [Channels*Bits-1:0]           data_o,
  output logic                               valid_o,
  output logic [DepthW-1:0]                  fill_o,
  output logic [Length*Channels*Bits-1:0]    taps_o
);

  localparam int unsigned LaneW = Channels * Bits;

  logic [LaneW-1:0]  stage_q [Length];
  logic [LaneW-1:0]  stage_d [Length];
  logic [DepthW-1:0] fill_q, fill_d;
  logic [DepthW-1:0] depth_q;
  logic [DepthW-1:0] depth_eff;
  logic              valid_q, valid_d;

  always_comb begin
    depth_eff = depth_i;
    if (depth_i == '0) begin
      depth_eff = DepthW'(1);
    end else if (depth_i > DepthW'(Length)) begin
      depth_eff = DepthW'(Length);
    end
  end

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (clear_i) begin
      for (int unsigned s = 0; s < Length; s++) begin
        stage_d[s] = {Channels{rst_val_i}};
      end
      fill_d = '0;
    end else begin
      // All stages move together; depth only selects where data_o is read.
      if (en_i) begin
        stage_d[0] = data_i;
        for (int unsigned s = 1; s < Length; s++) begin
          stage_d[s] = stage_q[s-1];
        end
      end
      if (depth_eff != depth_q) begin
        fill_d = '0;
      end else if (en_i) begin
        fill_d = (fill_q >= depth_eff) ? depth_eff : fill_q + DepthW'(1);
      end
    end
    valid_d = (fill_d == depth_eff);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < Length; s++) begin
        stage_q[s] <= {Channels{rst_val_i}};
      end
      fill_q  <= '0;
      valid_q <= 1'b0;
      depth_q <= DepthW'(1);
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      depth_q <= depth_eff;
    end
  end

  always_comb begin
    data_o = stage_q[0];
    for (int unsigned s = 1; s < Length; s++) begin
      if (depth_eff == DepthW'(s + 1)) begin
        data_o = stage_q[s];
      end
    end
  end

  assign fill_o  = fill_q;
  assign valid_o = valid_q;

`ifdef SHIFT_REG_TAPS_EN
  always_comb begin
    taps_o = '0;
    for (int unsigned s = 0; s < Length; s++) begin
      taps_o[s*LaneW +: LaneW] = stage_q[s];
    end
  end
`else
  assign taps_o = '0;
`endif

endmodule

// File: tb/tb_core_shift_reg_multi.sv
// Directed self-checking bench for core_shift_reg_multi (Bits=8, Channels=2, Length=4).
module tb_core_shift_reg_multi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        clear_i;
  logic [7:0]  rst_val_i;
  logic [2:0]  depth_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic [2:0]  fill_o;
  logic [63:0] taps_o;

  int n_cmp = 0;
  int n_err = 0;

  core_shift_reg_multi #(
    .Bits     (8),
    .Channels (2),
    .Length   (4)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .clear_i   (clear_i),
    .rst_val_i (rst_val_i),
    .depth_i   (depth_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .fill_o    (fill_o),
    .taps_o    (taps_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] taps_exp(input logic [63:0] v);
`ifdef SHIFT_REG_TAPS_EN
    return v;
`else
    return 64'h0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [15:0] d, input logic [2:0] f,
                             input logic v);
    check_eq({tag, ".data"}, 64'(data_o), 64'(d));
    check_eq({tag, ".fill"}, 64'(fill_o), 64'(f));
    check_eq({tag, ".valid"}, 64'(valid_o), 64'(v));
  endtask

  initial begin
    rst_i     = 1'b0;
    en_i      = 1'b0;
    clear_i   = 1'b0;
    rst_val_i = 8'hA5;
    depth_i   = 3'd3;
    data_i    = 16'h0;

    // Asynchronous reset seen before any clock edge
    #2 rst_i = 1'b1;
    #1;
    check_state("reset", 16'hA5A5, 3'd0, 1'b0);
    check_eq("reset.taps", taps_o, taps_exp(64'hA5A5_A5A5_A5A5_A5A5));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Depth 3: first edge sees depth change from reset value 1
    step();
    check_state("d3.idle", 16'hA5A5, 3'd0, 1'b0);
    en_i = 1'b1;
    data_i = 16'h1101; step(); check_state("d3.e1", 16'hA5A5, 3'd1, 1'b0);
    data_i = 16'h1202; step(); check_state("d3.e2", 16'hA5A5, 3'd2, 1'b0);
    data_i = 16'h1303; step(); check_state("d3.e3", 16'h1101, 3'd3, 1'b1);
    data_i = 16'h1404; step(); check_state("d3.e4", 16'h1202, 3'd3, 1'b1);
    check_eq("d3.taps", taps_o, taps_exp(64'h1101_1202_1303_1404));

    // Depth change 3 -> 4 while shifting: fill restarts, data still shifts
    depth_i = 3'd4;
    data_i = 16'h1505; step(); check_state("d4.chg", 16'h1202, 3'd0, 1'b0);
    data_i = 16'h1606; step(); check_state("d4.e1", 16'h1303, 3'd1, 1'b0);
    data_i = 16'h1707; step();
    data_i = 16'h1808; step();
    data_i = 16'h1909; step(); check_state("d4.e4", 16'h1606, 3'd4, 1'b1);

    // Depth change 4 -> 2: data_o switches combinationally, valid drops
    en_i = 1'b0;
    depth_i = 3'd2;
    #1;
    check_eq("d2.comb", 64'(data_o), 64'h1808);
    step(); check_state("d2.chg", 16'h1808, 3'd0, 1'b0);
    en_i = 1'b1;
    data_i = 16'h1A0A; step(); check_state("d2.e1", 16'h1909, 3'd1, 1'b0);
    data_i = 16'h1B0B; step(); check_state("d2.e2", 16'h1A0A, 3'd2, 1'b1);

    // Prime at depth 4, then clear together with enable
    en_i = 1'b0;
    depth_i = 3'd4;
    step(); check_eq("d4b.chg.fill", 64'(fill_o), 64'd0);
    en_i = 1'b1;
    data_i = 16'h1C0C; step();
    data_i = 16'h1D0D; step();
    data_i = 16'h1E0E; step();
    data_i = 16'h1F0F; step(); check_state("d4b.prim", 16'h1C0C, 3'd4, 1'b1);
    rst_val_i = 8'h00;
    clear_i = 1'b1;
    data_i = 16'h2020; step(); check_state("clear", 16'h0000, 3'd0, 1'b0);
    check_eq("clear.taps", taps_o, 64'h0);
    clear_i = 1'b0;

    // Gaps at depth 2: idle cycles neither shift nor count
    en_i = 1'b0;
    depth_i = 3'd2;
    step(); check_eq("gap.chg.fill", 64'(fill_o), 64'd0);
    en_i = 1'b1; data_i = 16'h1707; step(); check_state("gap.e1", 16'h0000, 3'd1, 1'b0);
    en_i = 1'b0; data_i = 16'h5555; step(); check_state("gap.idle", 16'h0000, 3'd1, 1'b0);
    en_i = 1'b1; data_i = 16'h1909; step(); check_state("gap.e2", 16'h1707, 3'd2, 1'b1);

    // depth_i=0 acts as depth 1
    en_i = 1'b0;
    depth_i = 3'd0;
    step(); check_state("d0.chg", 16'h1909, 3'd0, 1'b0);
    en_i = 1'b1; data_i = 16'h2121; step(); check_state("d0.e1", 16'h2121, 3'd1, 1'b1);

    // depth_i=7 acts as depth 4
    en_i = 1'b0;
    depth_i = 3'd7;
    step(); check_state("d7.chg", 16'h0000, 3'd0, 1'b0);
    en_i = 1'b1; data_i = 16'h2222; step(); check_state("d7.e1", 16'h1707, 3'd1, 1'b0);
    check_eq("d7.taps", taps_o, taps_exp(64'h1707_1909_2121_2222));

    // Asynchronous reset in mid-cycle discards everything
    rst_val_i = 8'h5A;
    data_i = 16'h2323;
    #3 rst_i = 1'b1;
    #1;
    check_state("midrst", 16'h5A5A, 3'd0, 1'b0);
    check_eq("midrst.taps", taps_o, taps_exp(64'h5A5A_5A5A_5A5A_5A5A));
    @(negedge clk_i);
    rst_i = 1'b0;
    en_i = 1'b0;
    step(); check_state("midrst.chg", 16'h5A5A, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
